// File: rtl/alu_design.sv
// Registered N-bit integer ALU: arithmetic/logical ops with a 2N-bit result and status flags.
// Multiplies take two edges; every other accepted op lands on the next edge.
module alu_design #(
    parameter int N = 8,
    parameter int M = 4
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           CE,
    input  logic [1:0]     INP_VALID,
    input  logic           MODE,
    input  logic [M-1:0]   CMD,
    input  logic [N-1:0]   OPA,
    input  logic [N-1:0]   OPB,
    input  logic           CIN,
    output logic [2*N-1:0] RES,
    output logic           OFLOW,
    output logic           COUT,
    output logic           G,
    output logic           E,
    output logic           L,
    output logic           ERR
);

    localparam int SH_W = $clog2(N);
    localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

    function automatic logic [2*N-1:0] zext_n(input logic [N-1:0] v);
        return {{N{1'b0}}, v};
    endfunction

    function automatic logic [2*N-1:0] zext_c(input logic [N:0] v);
        return {{(N-1){1'b0}}, v};
    endfunction

    // Rotation via a doubled word: the wanted bits fall in one half after a plain shift.
    function automatic logic [N-1:0] rotate(input logic [N-1:0] a, input logic [SH_W-1:0] sh,
                                            input logic left);
        logic [2*N-1:0] dbl;
        dbl = {a, a};
        if (left) begin
            dbl = dbl << sh;
            return dbl[2*N-1:N];
        end
        dbl = dbl >> sh;
        return dbl[N-1:0];
    endfunction

    logic [N:0]     add_s;
    logic [N:0]     addc_s;
    logic [N-1:0]   sub_d;
    logic [N-1:0]   subc_d;
    logic [N:0]     b_cin;
    logic           a_ok;
    logic           b_ok;
    logic           ab_ok;

    assign add_s  = {1'b0, OPA} + {1'b0, OPB};
    assign addc_s = add_s + {{N{1'b0}}, CIN};
    assign sub_d  = OPA - OPB;
    assign subc_d = sub_d - {{(N-1){1'b0}}, CIN};
    assign b_cin  = {1'b0, OPB} + {{N{1'b0}}, CIN};
    assign a_ok   = INP_VALID[0];
    assign b_ok   = INP_VALID[1];
    assign ab_ok  = &INP_VALID;

    logic [2*N-1:0] nxt_res;
    logic           nxt_oflow;
    logic           nxt_cout;
    logic           nxt_g;
    logic           nxt_e;
    logic           nxt_l;
    logic           nxt_err;
    logic           start_mul;
    logic           op_ok;
    int             cmd_i;

    always_comb begin
        nxt_res   = '0;
        nxt_oflow = 1'b0;
        nxt_cout  = 1'b0;
        nxt_g     = 1'b0;
        nxt_e     = 1'b0;
        nxt_l     = 1'b0;
        nxt_err   = 1'b0;
        start_mul = 1'b0;
        op_ok     = 1'b1;
        cmd_i     = int'(CMD);
        if (MODE) begin
            case (cmd_i)
                0: begin op_ok = ab_ok; nxt_res = zext_c(add_s);  nxt_cout = add_s[N];  end
                1: begin op_ok = ab_ok; nxt_res = zext_n(sub_d);  nxt_oflow = (OPA < OPB); end
                2: begin op_ok = ab_ok; nxt_res = zext_c(addc_s); nxt_cout = addc_s[N]; end
                3: begin op_ok = ab_ok; nxt_res = zext_n(subc_d); nxt_oflow = ({1'b0, OPA} < b_cin); end
                4: begin op_ok = a_ok; nxt_res = zext_n(OPA + ONE_N); nxt_cout  = &OPA;  end
                5: begin op_ok = a_ok; nxt_res = zext_n(OPA - ONE_N); nxt_oflow = ~|OPA; end
                6: begin op_ok = b_ok; nxt_res = zext_n(OPB + ONE_N); nxt_cout  = &OPB;  end
                7: begin op_ok = b_ok; nxt_res = zext_n(OPB - ONE_N); nxt_oflow = ~|OPB; end
                8: begin
                    op_ok = ab_ok;
                    nxt_g = (OPA > OPB);
                    nxt_e = (OPA == OPB);
                    nxt_l = (OPA < OPB);
                end
                9, 10: begin op_ok = ab_ok; start_mul = 1'b1; end
                default: nxt_err = 1'b1;
            endcase
        end else begin
            case (cmd_i)
                0:  begin op_ok = ab_ok; nxt_res = zext_n(OPA & OPB);    end
                1:  begin op_ok = ab_ok; nxt_res = zext_n(~(OPA & OPB)); end
                2:  begin op_ok = ab_ok; nxt_res = zext_n(OPA | OPB);    end
                3:  begin op_ok = ab_ok; nxt_res = zext_n(~(OPA | OPB)); end
                4:  begin op_ok = ab_ok; nxt_res = zext_n(OPA ^ OPB);    end
                5:  begin op_ok = ab_ok; nxt_res = zext_n(~(OPA ^ OPB)); end
                6:  begin op_ok = a_ok;  nxt_res = zext_n(~OPA);         end
                7:  begin op_ok = b_ok;  nxt_res = zext_n(~OPB);         end
                8:  begin op_ok = a_ok;  nxt_res = zext_n(OPA >> 1);     end
                9:  begin op_ok = a_ok;  nxt_res = zext_n(OPA << 1);     end
                10: begin op_ok = b_ok;  nxt_res = zext_n(OPB >> 1);     end
                11: begin op_ok = b_ok;  nxt_res = zext_n(OPB << 1);     end
                12, 13: begin
                    op_ok = ab_ok;
                    if (|OPB[N-1:SH_W])
                        nxt_err = 1'b1;
                    else
                        nxt_res = zext_n(rotate(OPA, OPB[SH_W-1:0], (cmd_i == 12)));
                end
                default: nxt_err = 1'b1;
            endcase
        end
        if (!op_ok)
            nxt_err = 1'b1;
        // An error forces a clean all-zero result and suppresses any multiply launch.
        if (nxt_err) begin
            nxt_res   = '0;
            nxt_oflow = 1'b0;
            nxt_cout  = 1'b0;
            nxt_g     = 1'b0;
            nxt_e     = 1'b0;
            nxt_l     = 1'b0;
            start_mul = 1'b0;
        end
    end

    // Stage p0: multiply operands captured; vld_p0 marks the busy cycle.
    logic           vld_p0;
    logic [N-1:0]   opa_p0;
    logic [N-1:0]   opb_p0;
    logic           sel_p0;
    logic [N:0]     a_inc_p0;
    logic [N:0]     b_inc_p0;
    logic [N-1:0]   a_shl_p0;
    logic [2*N-1:0] prod_inc_p0;
    logic [2*N-1:0] prod_shl_p0;

    always_ff @(posedge CLK) begin
        if (CE && !vld_p0 && start_mul) begin
            opa_p0 <= OPA;
            opb_p0 <= OPB;
            sel_p0 <= (cmd_i == 10);
        end
    end

    assign a_inc_p0    = {1'b0, opa_p0} + {1'b0, ONE_N};
    assign b_inc_p0    = {1'b0, opb_p0} + {1'b0, ONE_N};
    assign a_shl_p0    = opa_p0 << 1;
    assign prod_inc_p0 = {{(N-1){1'b0}}, a_inc_p0} * {{(N-1){1'b0}}, b_inc_p0};
    assign prod_shl_p0 = {{N{1'b0}}, a_shl_p0} * {{N{1'b0}}, opb_p0};

    // Stage p1: registered outputs.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            vld_p0 <= 1'b0;
            RES    <= '0;
            OFLOW  <= 1'b0;
            COUT   <= 1'b0;
            G      <= 1'b0;
            E      <= 1'b0;
            L      <= 1'b0;
            ERR    <= 1'b0;
        end else if (CE) begin
            if (vld_p0) begin
                vld_p0 <= 1'b0;
                RES    <= sel_p0 ? prod_shl_p0 : prod_inc_p0;
                OFLOW  <= 1'b0;
                COUT   <= 1'b0;
                G      <= 1'b0;
                E      <= 1'b0;
                L      <= 1'b0;
                ERR    <= 1'b0;
            end else if (start_mul) begin
                vld_p0 <= 1'b1;
            end else begin
                RES    <= nxt_res;
                OFLOW  <= nxt_oflow;
                COUT   <= nxt_cout;
                G      <= nxt_g;
                E      <= nxt_e;
                L      <= nxt_l;
                ERR    <= nxt_err;
            end
        end
    end

endmodule

// File: tb/tb_alu_design.sv
// Directed bench for alu_design: expected outputs are queued when an op is driven
// and popped one per clock edge for comparison.
module tb_alu_design;

    localparam int N = 8;
    localparam int M = 4;

    localparam logic [5:0] F_NONE = 6'b000000;
    localparam logic [5:0] F_OF   = 6'b100000;
    localparam logic [5:0] F_CO   = 6'b010000;
    localparam logic [5:0] F_G    = 6'b001000;
    localparam logic [5:0] F_E    = 6'b000100;
    localparam logic [5:0] F_L    = 6'b000010;
    localparam logic [5:0] F_ERR  = 6'b000001;

    logic           CLK = 1'b0;
    logic           RST;
    logic           CE;
    logic [1:0]     INP_VALID;
    logic           MODE;
    logic [M-1:0]   CMD;
    logic [N-1:0]   OPA;
    logic [N-1:0]   OPB;
    logic           CIN;
    logic [2*N-1:0] RES;
    logic           OFLOW, COUT, G, E, L, ERR;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2*N-1:0] res;
        logic [5:0]     flags;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    always #5 CLK = ~CLK;

    alu_design #(.N(N), .M(M)) dut (
        .CLK(CLK), .RST(RST), .CE(CE), .INP_VALID(INP_VALID), .MODE(MODE),
        .CMD(CMD), .OPA(OPA), .OPB(OPB), .CIN(CIN), .RES(RES),
        .OFLOW(OFLOW), .COUT(COUT), .G(G), .E(E), .L(L), .ERR(ERR)
    );

    task automatic drive(input logic mode, input logic [3:0] cmd, input logic [1:0] iv,
                         input logic [7:0] a, input logic [7:0] b, input logic c);
        MODE = mode; CMD = cmd; INP_VALID = iv; OPA = a; OPB = b; CIN = c;
    endtask

    task automatic push(input string t, input logic [15:0] r, input logic [5:0] f);
        exp_t x;
        x.res = r;
        x.flags = f;
        exp_q.push_back(x);
        tag_q.push_back(t);
    endtask

    task automatic check_out();
        exp_t  x;
        string t;
        logic [5:0] obs_f;
        obs_f = {OFLOW, COUT, G, E, L, ERR};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: observed res=%h flags=%b, no expectation queued", RES, obs_f);
        end else begin
            x = exp_q.pop_front();
            t = tag_q.pop_front();
            assert ({RES, obs_f} === {x.res, x.flags}) else begin
                errors++;
                $error("FAIL %s: observed res=%h flags=%b expected res=%h flags=%b",
                       t, RES, obs_f, x.res, x.flags);
            end
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        #1;
        check_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] ra, rb;
        logic [8:0] s;

        RST = 1'b0;
        CE  = 1'b1;
        drive(1'b0, 4'd0, 2'b00, 8'h00, 8'h00, 1'b0);
        push("reset", 16'h0000, F_NONE);
        cycle();
        RST = 1'b1;

        drive(1'b1, 4'd0, 2'b11, 8'hFF, 8'h01, 1'b0);
        push("add_carry", 16'h0100, F_CO);
        cycle();
        drive(1'b1, 4'd1, 2'b11, 8'h05, 8'h0A, 1'b0);
        push("sub_borrow", 16'h00FB, F_OF);
        cycle();
        drive(1'b1, 4'd8, 2'b11, 8'h3C, 8'h3C, 1'b0);
        push("cmp_eq", 16'h0000, F_E);
        cycle();
        drive(1'b1, 4'd8, 2'b11, 8'h50, 8'h3C, 1'b0);
        push("cmp_gt", 16'h0000, F_G);
        cycle();
        drive(1'b1, 4'd8, 2'b11, 8'h10, 8'h3C, 1'b0);
        push("cmp_lt", 16'h0000, F_L);
        cycle();
        drive(1'b1, 4'd2, 2'b11, 8'h7F, 8'h80, 1'b1);
        push("add_cin", 16'h0100, F_CO);
        cycle();
        drive(1'b1, 4'd3, 2'b11, 8'h05, 8'h05, 1'b1);
        push("sub_cin", 16'h00FF, F_OF);
        cycle();
        drive(1'b1, 4'd5, 2'b01, 8'h00, 8'h77, 1'b0);
        push("dec_a_zero", 16'h00FF, F_OF);
        cycle();
        drive(1'b1, 4'd6, 2'b10, 8'h99, 8'h10, 1'b0);
        push("inc_b", 16'h0011, F_NONE);
        cycle();
        drive(1'b1, 4'd4, 2'b10, 8'h10, 8'h10, 1'b0);
        push("inc_a_no_a", 16'h0000, F_ERR);
        cycle();
        drive(1'b1, 4'd0, 2'b01, 8'h12, 8'h34, 1'b0);
        push("add_only_a", 16'h0000, F_ERR);
        cycle();
        drive(1'b1, 4'd12, 2'b11, 8'h12, 8'h34, 1'b0);
        push("arith_cmd12", 16'h0000, F_ERR);
        cycle();

        drive(1'b0, 4'd0, 2'b11, 8'hF0, 8'h3C, 1'b0);
        push("and", 16'h0030, F_NONE);
        cycle();
        drive(1'b0, 4'd1, 2'b11, 8'hF0, 8'h3C, 1'b0);
        push("nand", 16'h00CF, F_NONE);
        cycle();
        drive(1'b0, 4'd5, 2'b11, 8'hF0, 8'h3C, 1'b0);
        push("xnor", 16'h0033, F_NONE);
        cycle();
        drive(1'b0, 4'd9, 2'b01, 8'h81, 8'h00, 1'b0);
        push("shl_a", 16'h0002, F_NONE);
        cycle();
        drive(1'b0, 4'd12, 2'b11, 8'h81, 8'h01, 1'b0);
        push("rol", 16'h0003, F_NONE);
        cycle();
        drive(1'b0, 4'd13, 2'b11, 8'h81, 8'h01, 1'b0);
        push("ror", 16'h00C0, F_NONE);
        cycle();
        drive(1'b0, 4'd12, 2'b11, 8'h81, 8'h10, 1'b0);
        push("rol_bad_amt", 16'h0000, F_ERR);
        cycle();
        drive(1'b0, 4'd14, 2'b11, 8'h81, 8'h01, 1'b0);
        push("logic_cmd14", 16'h0000, F_ERR);
        cycle();

        // Multiply: outputs hold through the busy cycle, which also ignores its inputs.
        drive(1'b0, 4'd4, 2'b11, 8'hF0, 8'h3C, 1'b0);
        push("xor", 16'h00CC, F_NONE);
        cycle();
        drive(1'b1, 4'd9, 2'b11, 8'h03, 8'h04, 1'b0);
        push("mul_hold", 16'h00CC, F_NONE);
        cycle();
        drive(1'b1, 4'd0, 2'b11, 8'h01, 8'h01, 1'b0);
        push("mul_inc", 16'd20, F_NONE);
        cycle();
        drive(1'b1, 4'd9, 2'b11, 8'hFF, 8'h01, 1'b0);
        push("mul_wide_hold", 16'd20, F_NONE);
        cycle();
        drive(1'b0, 4'd0, 2'b00, 8'h00, 8'h00, 1'b0);
        push("mul_wide", 16'h0200, F_NONE);
        cycle();
        drive(1'b1, 4'd10, 2'b11, 8'h81, 8'h03, 1'b0);
        push("mul_shl_hold", 16'h0200, F_NONE);
        cycle();
        drive(1'b1, 4'd1, 2'b11, 8'h01, 8'h09, 1'b0);
        push("mul_shl", 16'h0006, F_NONE);
        cycle();

        // Clock enable low: new inputs are ignored and outputs hold.
        drive(1'b1, 4'd0, 2'b11, 8'h01, 8'h02, 1'b0);
        push("add_small", 16'h0003, F_NONE);
        cycle();
        CE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'd0, 2'b11, 8'hFF, 8'(i), 1'b0);
            push("ce_hold", 16'h0003, F_NONE);
            cycle();
        end
        CE = 1'b1;

        // CE low mid-multiply freezes the pipeline.
        drive(1'b1, 4'd9, 2'b11, 8'h02, 8'h02, 1'b0);
        push("mul_ce_busy", 16'h0003, F_NONE);
        cycle();
        CE = 1'b0;
        drive(1'b1, 4'd0, 2'b11, 8'h40, 8'h40, 1'b0);
        push("mul_ce_frozen1", 16'h0003, F_NONE);
        cycle();
        push("mul_ce_frozen2", 16'h0003, F_NONE);
        cycle();
        CE = 1'b1;
        push("mul_ce_resume", 16'd9, F_NONE);
        cycle();

        // Reset mid-multiply discards the product.
        drive(1'b1, 4'd9, 2'b11, 8'h05, 8'h05, 1'b0);
        push("mul_rst_busy", 16'd9, F_NONE);
        cycle();
        RST = 1'b0;
        push("mul_rst", 16'h0000, F_NONE);
        cycle();
        RST = 1'b1;
        drive(1'b0, 4'd0, 2'b11, 8'h0F, 8'hFF, 1'b0);
        push("after_rst_and", 16'h000F, F_NONE);
        cycle();

        // Reset takes effect even with CE low.
        CE  = 1'b0;
        RST = 1'b0;
        push("rst_over_ce", 16'h0000, F_NONE);
        cycle();
        RST = 1'b1;
        CE  = 1'b1;

        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            s  = {1'b0, ra} + {1'b0, rb};
            drive(1'b1, 4'd0, 2'b11, ra, rb, 1'b0);
            push("add_rand", {7'd0, s}, s[8] ? F_CO : F_NONE);
            cycle();
        end

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: %0d expectations never compared, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_design.md
Name: alu_design

Overview:
- Registered, parameterised integer ALU with one clock and selectable arithmetic/logical mode.
- Produces a double-width result plus carry, overflow, compare and error flags.
- Leaf datapath block; driven through the team's ALU interface.
- Checked by the ALU assertion module, which observes CLK, RST, CE, OPA, OPB, MODE, INP_VALID, CMD, CIN and RES.

Parameters:
- N, 8, operand width in bits.
- M, 4, command width in bits.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous reset, active-low.
- CE  input  1  clock enable; when 0, all state and outputs hold.
- INP_VALID  input  2  operand validity: 00 none, 01 OPA only, 10 OPB only, 11 both.
- MODE  input  1  1 = arithmetic, 0 = logical.
- CMD  input  M  operation select.
- OPA  input  N  operand A.
- OPB  input  N  operand B.
- CIN  input  1  carry-in.
- RES  output  2N  result, zero-extended.
- OFLOW  output  1  overflow/borrow flag.
- COUT  output  1  carry-out flag.
- G  output  1  A > B (CMP only).
- E  output  1  A == B (CMP only).
- L  output  1  A < B (CMP only).
- ERR  output  1  error flag.

Behaviour:
- Reset: on a rising edge with RST=0, RES=0, all flags=0, multiply pipeline cleared. Reset overrides CE and any op in flight.
- CE=0: inputs ignored; outputs and pipeline state hold.
- Update rule: each accepted operation rewrites every output. Flags the op does not define are driven 0.
- Latency: non-multiply ops present results at the first rising edge after sampling.
- Multiply latency: CMD 9/10 present results at the second edge.
- Multiply busy cycle: inputs presented in the cycle after a multiply is sampled are ignored; outputs hold during that cycle.
- Operand requirements: single-operand ops need the relevant bit of INP_VALID. Two-operand ops need 11.
- ERR conditions: insufficient INP_VALID, or undefined CMD. When ERR=1: RES=0 and all other flags 0.
- Arithmetic ops (MODE=1):
  - 0 ADD: RES=A+B; COUT=bit N of the sum.
  - 1 SUB: RES=A-B, N-bit wrap; OFLOW=1 if A<B.
  - 2 ADD_CIN: RES=A+B+CIN; COUT=bit N.
  - 3 SUB_CIN: RES=A-B-CIN, N-bit wrap; OFLOW=1 if A<B+CIN.
  - 4 INC_A: RES=A+1; COUT on wrap from all-ones.
  - 5 DEC_A: RES=A-1; OFLOW when A=0.
  - 6 INC_B and 7 DEC_B: as 4 and 5, applied to B.
  - 8 CMP: RES=0; exactly one of G/E/L set.
  - 9: RES=(A+1)*(B+1), full 2N bits.
  - 10: RES=((A<<1) mod 2^N)*B.
  - 11–15: ERR.
- Logical ops (MODE=0), results N bits zero-extended:
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR.
  - 6 NOT_A, 7 NOT_B.
  - 8 A>>1, 9 A<<1, 10 B>>1, 11 B<<1 (logical, zero fill).
  - 12 ROL A by OPB[log2N-1:0], 13 ROR A by OPB[log2N-1:0].
  - Rotates: ERR=1 if any OPB bit above log2N-1 is set.
  - 14–15: ERR.
- Reset mid-multiply: the result is discarded; RES stays 0.
- CE low during a multiply: the pipeline freezes and resumes when CE returns to 1.

Test Plan:
- Reset: RST=0 one edge, then RST=1 → RES=0, all flags 0.
- Arithmetic add: MODE=1, CMD=0, INP_VALID=11, OPA=0xFF, OPB=0x01 → next edge RES=0x100, COUT=1.
- Arithmetic subtract: MODE=1, CMD=1, OPA=0x05, OPB=0x0A → RES=0xFB, OFLOW=1.
- Compare: MODE=1, CMD=8, OPA=OPB=0x3C → E=1, G=L=0, RES=0.
- Multiply: MODE=1, CMD=9, OPA=0x03, OPB=0x04 → RES=20 after 2 edges. The op applied in the busy cycle is ignored.
- Logical ops and errors:
  - MODE=0, CMD=12, OPA=0x81, OPB=0x01 → RES=0x03.
  - Same op with OPB=0x10 → ERR=1, RES=0.
  - INP_VALID=01 with CMD=0 → ERR=1.
- CE hold: CE=0 with new inputs → outputs hold for 3 cycles.
